// File: rtl/tt_um_accelshark_psg_i2s_rx_if.sv
// Signal bundle between an I2S source (master) and the PSG I2S receiver (slave).
// The slot_err/err_cnt fields exist only when PSG_I2S_RX_ERR_EN is defined.
interface tt_um_accelshark_psg_i2s_rx_if #(
    parameter int WIDTH = 16
);
    logic             ena;
    logic             lrck;
    logic             sdata;
    logic [WIDTH-1:0] data_l;
    logic [WIDTH-1:0] data_r;
    logic             valid;
    logic             locked;
`ifdef PSG_I2S_RX_ERR_EN
    logic             slot_err;
    logic [7:0]       err_cnt;
`endif

    modport master (
        output ena, lrck, sdata,
        input  data_l, data_r, valid, locked
`ifdef PSG_I2S_RX_ERR_EN
        , input slot_err, err_cnt
`endif
    );

    modport slave (
        input  ena, lrck, sdata,
        output data_l, data_r, valid, locked
`ifdef PSG_I2S_RX_ERR_EN
        , output slot_err, err_cnt
`endif
    );
endinterface

// File: rtl/tt_um_accelshark_psg_i2s_rx.sv
// Stereo I2S receiver: rebuilds a coherent left/right word pair per lrck frame.
// Optional slot-error pulse and saturating error counter under PSG_I2S_RX_ERR_EN.
module tt_um_accelshark_psg_i2s_rx #(
    parameter int WIDTH     = 16,
    parameter int SLOT_BITS = 32
) (
    input  logic                          sclk,
    input  logic                          rst_n,
    tt_um_accelshark_psg_i2s_rx_if.slave  rx
);
    localparam int NW = $clog2(SLOT_BITS + 1);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        DUMMY = 2'd1,
        SHIFT = 2'd2,
        PAD   = 2'd3
    } state_t;

    state_t           state_q;
    logic             lrck_q;
    logic [NW-1:0]    n_q;
    logic [WIDTH-2:0] shift_q;
    logic [WIDTH-1:0] stage_l_q;
    logic             left_ok_q;
    logic [WIDTH-1:0] data_l_q;
    logic [WIDTH-1:0] data_r_q;
    logic             valid_q;
    logic             locked_q;

    logic             edge_s;
    logic             in_slot_s;
    logic [NW-1:0]    n_d;
    logic [WIDTH-1:0] word_s;
    logic             short_s;
    logic             slot_end_s;
    logic             long_s;

    // Bit index and slot-boundary events; n saturates so a stuck lrck is detectable
    always_comb begin
        edge_s    = (rx.lrck != lrck_q);
        in_slot_s = (state_q == DUMMY) || (state_q == SHIFT);
        word_s    = {shift_q, rx.sdata};
        if (edge_s) begin
            n_d = {NW{1'b0}};
        end else if (n_q == NW'(SLOT_BITS)) begin
            n_d = n_q;
        end else begin
            n_d = n_q + NW'(1);
        end
        short_s    = rx.ena && edge_s && in_slot_s;
        slot_end_s = rx.ena && !edge_s && in_slot_s && (n_d == NW'(WIDTH));
        long_s     = rx.ena && !edge_s && (state_q == PAD) && (n_d == NW'(SLOT_BITS));
    end

    // Slot FSM, deserialiser, left staging and registered outputs
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SYNC;
            lrck_q    <= 1'b0;
            n_q       <= {NW{1'b0}};
            shift_q   <= {(WIDTH-1){1'b0}};
            stage_l_q <= {WIDTH{1'b0}};
            left_ok_q <= 1'b0;
            data_l_q  <= {WIDTH{1'b0}};
            data_r_q  <= {WIDTH{1'b0}};
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            lrck_q  <= rx.lrck;
            n_q     <= n_d;
            valid_q <= 1'b0;
            if (!rx.ena) begin
                state_q   <= SYNC;
                locked_q  <= 1'b0;
                left_ok_q <= 1'b0;
            end else begin
                case (state_q)
                    SYNC: begin
                        if (edge_s) begin
                            state_q <= DUMMY;
                        end else begin
                            state_q <= SYNC;
                        end
                    end
                    DUMMY, SHIFT: begin
                        if (short_s) begin
                            // Truncated slot: drop the word and any pending left half, restart now
                            state_q   <= DUMMY;
                            locked_q  <= 1'b0;
                            left_ok_q <= 1'b0;
                        end else begin
                            shift_q <= word_s[WIDTH-2:0];
                            if (slot_end_s) begin
                                state_q  <= PAD;
                                locked_q <= 1'b1;
                                if (!lrck_q) begin
                                    stage_l_q <= word_s;
                                    left_ok_q <= 1'b1;
                                end else if (left_ok_q) begin
                                    data_l_q  <= stage_l_q;
                                    data_r_q  <= word_s;
                                    valid_q   <= 1'b1;
                                    left_ok_q <= 1'b0;
                                end else begin
                                    left_ok_q <= 1'b0;
                                end
                            end else begin
                                state_q <= SHIFT;
                            end
                        end
                    end
                    PAD: begin
                        if (edge_s) begin
                            state_q <= DUMMY;
                        end else if (long_s) begin
                            state_q   <= SYNC;
                            locked_q  <= 1'b0;
                            left_ok_q <= 1'b0;
                        end else begin
                            state_q <= PAD;
                        end
                    end
                    default: begin
                        state_q <= SYNC;
                    end
                endcase
            end
        end
    end

    assign rx.data_l = data_l_q;
    assign rx.data_r = data_r_q;
    assign rx.valid  = valid_q;
    assign rx.locked = locked_q;

`ifdef PSG_I2S_RX_ERR_EN
    logic       slot_err_q;
    logic [7:0] err_cnt_q;

    // Error pulse and saturating count of short/long slot events
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            slot_err_q <= 1'b0;
            err_cnt_q  <= 8'h00;
        end else begin
            slot_err_q <= short_s || long_s;
            if ((short_s || long_s) && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end else begin
                err_cnt_q <= err_cnt_q;
            end
        end
    end

    assign rx.slot_err = slot_err_q;
    assign rx.err_cnt  = err_cnt_q;
`endif
endmodule
